multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: control unit for a multicycle MIPS-style datapath.
//
// Sequences each instruction through FETCH, DECODE, EXEC and, when needed,
// MEM and WB, driving the datapath strobes and ALU operation code for each
// step. Counts retired instructions and parks in TRAP on an illegal
// opcode/funct until reset.
//
// Ports
//   clk_i          single clock, rising edge
//   rst_i          asynchronous active-high reset
//   opcode_i       instruction bits [31:26]
//   funct_i        instruction bits [5:0]
//   zero_i         ALU zero flag (branch resolution)
//   mem_ready_i    memory completes the current access this cycle
//   state_o        current FSM state code
//   mem_read_o, mem_write_o               memory strobes
//   ir_write_o, pc_write_o, reg_write_o   register write enables
//   pc_src_o       00 pc+4, 01 branch target, 10 jump target
//   reg_dst_o      1 = rd, 0 = rt
//   mem_to_reg_o   1 = memory data, 0 = ALU result
//   alu_src_o      0 = read_data_2, 1 = sign-extended immediate
//   alu_control_o  ALU operation code
//   retire_o       one-cycle pulse per completed instruction
//   instr_count_o  retired-instruction count (wraps)
//   trap_o         high while in TRAP
//
// State | meaning
// ------+----------------------------------------------
// 0     | FETCH  : read instruction, wait for memory
// 1     | DECODE : latch opcode/funct, check legality
// 2     | EXEC   : ALU operation / branch / jump
// 3     | MEM    : load or store, wait for memory
// 4     | WB     : register file write
// 7     | TRAP   : illegal instruction, held until reset
// 5, 6  | unused, fall into TRAP

module multicycle_control #(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [5:0]             opcode_i,
    input  logic [5:0]             funct_i,
    input  logic                   zero_i,
    input  logic                   mem_ready_i,
    output logic [2:0]             state_o,
    output logic                   mem_read_o,
    output logic                   mem_write_o,
    output logic                   ir_write_o,
    output logic                   pc_write_o,
    output logic                   reg_write_o,
    output logic [1:0]             pc_src_o,
    output logic                   reg_dst_o,
    output logic                   mem_to_reg_o,
    output logic                   alu_src_o,
    output logic [3:0]             alu_control_o,
    output logic                   retire_o,
    output logic [COUNT_WIDTH-1:0] instr_count_o,
    output logic                   trap_o
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd7;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_NOR = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    logic [2:0]             state_q, state_d;
    logic [5:0]             opcode_q, opcode_d;
    logic [5:0]             funct_q, funct_d;
    logic [COUNT_WIDTH-1:0] instr_count_q, instr_count_d;
    logic                   legal_w;
    logic                   is_mem_op_w;

    // R-type ALU operation; 4'hF marks an unsupported funct.
    function automatic logic [3:0] rtype_alu(input logic [5:0] f);
        case (f)
            6'h20, 6'h21: rtype_alu = ALU_ADD;
            6'h22, 6'h23: rtype_alu = ALU_SUB;
            6'h24:        rtype_alu = ALU_AND;
            6'h25:        rtype_alu = ALU_OR;
            6'h26:        rtype_alu = ALU_XOR;
            6'h27:        rtype_alu = ALU_NOR;
            6'h2A:        rtype_alu = ALU_SLT;
            default:      rtype_alu = 4'hF;
        endcase
    endfunction

    // Legality is judged on the live inputs while in DECODE; later states
    // only look at the latched copies.
    always_comb begin
        legal_w = 1'b0;
        case (opcode_i)
            OP_RTYPE: legal_w = (rtype_alu(funct_i) != 4'hF);
            OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI,
            OP_ANDI, OP_ORI, OP_LW, OP_SW: legal_w = 1'b1;
            default:  legal_w = 1'b0;
        endcase
    end

    assign is_mem_op_w = (opcode_q == OP_LW) || (opcode_q == OP_SW);

    // State register and datapath-side registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= S_FETCH;
            opcode_q      <= '0;
            funct_q       <= '0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            opcode_q      <= opcode_d;
            funct_q       <= funct_d;
            instr_count_q <= instr_count_d;
        end
    end

    always_comb begin
        opcode_d      = (state_q == S_DECODE) ? opcode_i : opcode_q;
        funct_d       = (state_q == S_DECODE) ? funct_i  : funct_q;
        instr_count_d = instr_count_q + {{(COUNT_WIDTH-1){1'b0}}, retire_o};
    end

    // Next-state logic.
    always_comb begin
        state_d = S_TRAP;
        case (state_q)
            S_FETCH:  state_d = mem_ready_i ? S_DECODE : S_FETCH;
            S_DECODE: state_d = legal_w ? S_EXEC : S_TRAP;
            S_EXEC: begin
                case (opcode_q)
                    OP_RTYPE: state_d = (rtype_alu(funct_q) != 4'hF) ? S_WB : S_TRAP;
                    OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI: state_d = S_WB;
                    OP_LW, OP_SW:        state_d = S_MEM;
                    OP_BEQ, OP_BNE, OP_J: state_d = S_FETCH;
                    default:             state_d = S_TRAP;
                endcase
            end
            S_MEM: begin
                if (!is_mem_op_w)
                    state_d = S_TRAP;
                else if (!mem_ready_i)
                    state_d = S_MEM;
                else
                    state_d = (opcode_q == OP_LW) ? S_WB : S_FETCH;
            end
            S_WB:    state_d = S_FETCH;
            default: state_d = S_TRAP;
        endcase
    end

    // Output logic. Gating on rst_i keeps every strobe low for the whole
    // reset window, not just from the reset edge onward.
    always_comb begin
        mem_read_o    = 1'b0;
        mem_write_o   = 1'b0;
        ir_write_o    = 1'b0;
        pc_write_o    = 1'b0;
        reg_write_o   = 1'b0;
        pc_src_o      = 2'b00;
        reg_dst_o     = 1'b0;
        mem_to_reg_o  = 1'b0;
        alu_src_o     = 1'b0;
        alu_control_o = ALU_AND;
        retire_o      = 1'b0;
        trap_o        = 1'b0;
        if (!rst_i) begin
            case (state_q)
                S_FETCH: begin
                    mem_read_o = 1'b1;
                    if (mem_ready_i) begin
                        ir_write_o = 1'b1;
                        pc_write_o = 1'b1;
                    end
                end
                S_EXEC: begin
                    case (opcode_q)
                        OP_RTYPE: begin
                            if (rtype_alu(funct_q) != 4'hF)
                                alu_control_o = rtype_alu(funct_q);
                        end
                        OP_LW, OP_SW, OP_ADDI, OP_ADDIU: begin
                            alu_src_o     = 1'b1;
                            alu_control_o = ALU_ADD;
                        end
                        OP_SLTI: begin
                            alu_src_o     = 1'b1;
                            alu_control_o = ALU_SLT;
                        end
                        OP_ANDI: begin
                            alu_src_o     = 1'b1;
                            alu_control_o = ALU_AND;
                        end
                        OP_ORI: begin
                            alu_src_o     = 1'b1;
                            alu_control_o = ALU_OR;
                        end
                        OP_BEQ, OP_BNE: begin
                            alu_control_o = ALU_SUB;
                            pc_src_o      = 2'b01;
                            pc_write_o    = (opcode_q == OP_BEQ) ? zero_i : !zero_i;
                            retire_o      = 1'b1;
                        end
                        OP_J: begin
                            pc_src_o   = 2'b10;
                            pc_write_o = 1'b1;
                            retire_o   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    if (is_mem_op_w) begin
                        alu_src_o     = 1'b1;
                        alu_control_o = ALU_ADD;
                        if (opcode_q == OP_LW) begin
                            mem_read_o = 1'b1;
                        end else begin
                            mem_write_o = 1'b1;
                            retire_o    = mem_ready_i;
                        end
                    end
                end
                S_WB: begin
                    reg_write_o  = 1'b1;
                    reg_dst_o    = (opcode_q == OP_RTYPE);
                    mem_to_reg_o = (opcode_q == OP_LW);
                    retire_o     = 1'b1;
                end
                S_TRAP: trap_o = 1'b1;
                default: ;
            endcase
        end
    end

    assign state_o       = state_q;
    assign instr_count_o = instr_count_q;

endmodule
